// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, datapath width and right-shifter FSM states.
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  localparam logic [5:0] SIG_SLL = 6'b000001;
  localparam logic [5:0] SIG_SRL = 6'b000010;
  localparam logic [5:0] SIG_SRA = 6'b000011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;
endpackage

// File: rtl/shift_stage_right.sv
// One logarithmic right-shift stage: optionally shifts by amt_i, filling vacated bits with fill_i.
module shift_stage_right #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [4:0]       amt_i,
  input  logic             en_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] acc_o
);
  logic [2*WIDTH-1:0] ext;

  always_comb begin
    // Prepend a word of fill bits so a plain shift brings them in from the top.
    ext   = {{WIDTH{fill_i}}, acc_i};
    acc_o = en_i ? WIDTH'(ext >> amt_i) : acc_i;
  end
endmodule

// File: rtl/shifter_right_seq.sv
// Multi-cycle SRL/SRA unit: captures one operand on start, applies stages 16,8,4,2,1 one per clock.
module shifter_right_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH = ALU_WIDTH,
  parameter logic [5:0] SRL   = SIG_SRL,
  parameter logic [5:0] SRA   = SIG_SRA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);
  state_e           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       shamt_q, shamt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic [WIDTH-1:0] stage_acc;
  logic [4:0]       stage_amt;
  logic             stage_en;
  logic             stage_fill;
  logic             unused_dataB;

  assign unused_dataB = ^dataB[WIDTH-1:5];

  // Stage k shifts by 16>>k, gated by the matching shamt bit (MSB first).
  assign stage_amt  = 5'd16 >> k_q;
  assign stage_en   = shamt_q[3'd4 - k_q];
  assign stage_fill = mode_q & acc_q[WIDTH-1];

  shift_stage_right #(.WIDTH(WIDTH)) u_stage (
    .acc_i  (acc_q),
    .amt_i  (stage_amt),
    .en_i   (stage_en),
    .fill_i (stage_fill),
    .acc_o  (stage_acc)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      SHIFT: begin
        acc_d = stage_acc;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd4) begin
          state_d = DONE;
          done_d  = 1'b1;
          dout_d  = stage_acc;
          k_d     = 3'd0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new start, giving back-to-back throughput.
        state_d = IDLE;
        if (start) begin
          if (Signal == SRL || Signal == SRA) begin
            acc_d   = dataA;
            shamt_d = dataB[4:0];
            mode_d  = (Signal == SRA);
            k_d     = 3'd0;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            dout_d  = '0;
          end
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      acc_q   <= '0;
      shamt_q <= 5'd0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = dout_q;
endmodule

// File: tb/tb_shifter_right_seq.sv
// Scoreboard bench for shifter_right_seq: stimulus pushes expected results, a monitor checks each done.
module tb_shifter_right_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic        busy, done;
  logic [31:0] dataOut;

  shifter_right_seq dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .Signal(Signal), .busy(busy), .done(done), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got dataOut %h at cycle %0d with nothing outstanding", dataOut, cyc);
      end else begin
        e = sb.pop_front();
        chk("dataOut", dataOut, e.data);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] s);
    @(negedge clk);
    dataA = a; dataB = b; Signal = s; start = 1'b1;
  endtask

  task automatic scramble();
    dataA = $urandom; dataB = $urandom; Signal = 6'($urandom);
  endtask

  task automatic wait_idle(output int bcnt);
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      else break;
    end
    if (bcnt >= 30) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, bcnt);
    end
  endtask

  task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                    input logic [5:0] s, input logic [31:0] exp, input int lat);
    int bc;
    issue(a, b, s);
    @(posedge clk); #1;
    sb.push_back('{exp, cyc + lat});
    start = 1'b0;
    scramble();
    wait_idle(bc);
    chk({name, "_busy_cycles"}, bc, lat + 1);
  endtask

  initial begin
    int d0, bc;
    // Reset held low while start toggles: outputs must stay cleared.
    dataA = 32'hDEAD_BEEF; dataB = 32'd4; Signal = SIG_SRL;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = ~start;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dataOut", dataOut, 0);
    end
    @(negedge clk); start = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_dataOut", dataOut, 0);

    op("srl4",    32'h8000_00F0, 32'd4,         SIG_SRL, 32'h0800_000F, 5);
    op("srl16",   32'hABCD_1234, 32'd16,        SIG_SRL, 32'h0000_ABCD, 5);
    op("srl31",   32'h8000_00F0, 32'd31,        SIG_SRL, 32'h0000_0001, 5);
    op("sra4",    32'h8000_00F0, 32'd4,         SIG_SRA, 32'hF800_000F, 5);
    op("sra31",   32'h8000_00F0, 32'd31,        SIG_SRA, 32'hFFFF_FFFF, 5);
    op("sra0",    32'h8000_00F0, 32'h0000_0020, SIG_SRA, 32'h8000_00F0, 5);
    op("sra_pos", 32'h7000_0000, 32'd16,        SIG_SRA, 32'h0000_7000, 5);
    op("sra21",   32'hC000_0000, 32'hFFFF_FFF5, SIG_SRA, 32'hFFFF_FE00, 5);
    op("illegal", 32'h1234_5678, 32'd4,         SIG_SLL, 32'h0000_0000, 0);

    // start held through SHIFT must not launch a second operation.
    d0 = done_cnt;
    issue(32'h0000_FF00, 32'd8, SIG_SRL);
    @(posedge clk); #1;
    sb.push_back('{32'h0000_00FF, cyc + 5});
    dataA = 32'h5555_5555; Signal = SIG_SLL;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_idle(bc);
    repeat (3) @(negedge clk);
    chk("held_start_one_done", done_cnt - d0, 1);

    // Back-to-back: start stays high so DONE accepts the second operation.
    issue(32'hFFFF_FFFF, 32'd31, SIG_SRL);
    @(posedge clk); #1;
    sb.push_back('{32'h0000_0001, cyc + 5});
    dataA = 32'h7FFF_FFFF; dataB = 32'd1; Signal = SIG_SRA;
    repeat (6) @(posedge clk);
    #1;
    sb.push_back('{32'h3FFF_FFFF, cyc + 5});
    start = 1'b0;
    scramble();
    wait_idle(bc);
    chk("b2b_busy_cycles", bc, 6);

    // Abort in the third SHIFT cycle.
    d0 = done_cnt;
    issue(32'hF000_0000, 32'd4, SIG_SRA);
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dataOut", dataOut, 0);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    op("post_abort", 32'h8000_0000, 32'd1, SIG_SRA, 32'hC000_0000, 5);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
